// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: folds MSB-first 2-bit digit verdicts
// into one registered eq/gt/lt result per NDIGITS-digit frame.
module serial_mag_compare #(
    parameter int NDIGITS = 4,
    parameter int CNT_W   = $clog2(NDIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_eq,
    input  logic             in_gt,
    input  logic             in_lt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_err,
    output logic [CNT_W-1:0] digit_cnt
);

    typedef enum logic {ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_dec, w_dec;
    logic             r_gt, w_gt;
    logic             r_lt, w_lt;
    logic             r_err, w_err;
    logic             r_res_eq, w_res_eq;
    logic             r_res_gt, w_res_gt;
    logic             r_res_lt, w_res_lt;

    logic w_accept;
    logic w_dig_gt;
    logic w_dig_lt;
    logic w_illegal;

    assign w_accept  = in_valid & (r_state == ACCUM);
    assign w_dig_gt  = in_gt & ~in_eq & ~in_lt;
    assign w_dig_lt  = in_lt & ~in_eq & ~in_gt;
    // Anything other than a single set flag is illegal and acts as "equal"
    assign w_illegal = ~((in_eq ^ in_gt ^ in_lt) & ~(in_eq & in_gt & in_lt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ACCUM;
            r_cnt    <= '0;
            r_dec    <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_err    <= 1'b0;
            r_res_eq <= 1'b0;
            r_res_gt <= 1'b0;
            r_res_lt <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_dec    <= w_dec;
            r_gt     <= w_gt;
            r_lt     <= w_lt;
            r_err    <= w_err;
            r_res_eq <= w_res_eq;
            r_res_gt <= w_res_gt;
            r_res_lt <= w_res_lt;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_dec    = r_dec;
        w_gt     = r_gt;
        w_lt     = r_lt;
        w_err    = r_err;
        w_res_eq = r_res_eq;
        w_res_gt = r_res_gt;
        w_res_lt = r_res_lt;
        unique case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_cnt = r_cnt + 1'b1;
                    // First non-equal legal digit wins; later ones are ignored
                    if (!r_dec && w_dig_gt) begin
                        w_gt  = 1'b1;
                        w_dec = 1'b1;
                    end
                    if (!r_dec && w_dig_lt) begin
                        w_lt  = 1'b1;
                        w_dec = 1'b1;
                    end
                    if (w_illegal) w_err = 1'b1;
                    if (r_cnt == LAST) begin
                        w_cnt    = '0;
                        w_state  = DONE;
                        w_res_gt = w_gt;
                        w_res_lt = w_lt;
                        w_res_eq = ~w_dec;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state  = ACCUM;
                    w_dec    = 1'b0;
                    w_gt     = 1'b0;
                    w_lt     = 1'b0;
                    w_err    = 1'b0;
                    w_res_eq = 1'b0;
                    w_res_gt = 1'b0;
                    w_res_lt = 1'b0;
                end
            end
            default: w_state = ACCUM;
        endcase
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign res_eq    = r_res_eq;
    assign res_gt    = r_res_gt;
    assign res_lt    = r_res_lt;
    assign res_err   = r_err;
    assign digit_cnt = r_cnt;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare: directed frames plus random operand
// pairs checked against a digit-scan reference model.
module tb_serial_mag_compare;

    localparam int N  = 4;
    localparam int CW = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_eq;
    logic          in_gt;
    logic          in_lt;
    logic          out_valid;
    logic          out_ready;
    logic          res_eq;
    logic          res_gt;
    logic          res_lt;
    logic          res_err;
    logic [CW-1:0] digit_cnt;

    int checks;
    int errors;

    serial_mag_compare #(.NDIGITS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_eq    (in_eq),
        .in_gt    (in_gt),
        .in_lt    (in_lt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_eq   (res_eq),
        .res_gt   (res_gt),
        .res_lt   (res_lt),
        .res_err  (res_err),
        .digit_cnt(digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    // All driving happens on the falling edge; flags are {eq,gt,lt}
    task automatic send(input logic [2:0] f, input int gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        {in_eq, in_gt, in_lt} = f;
        @(negedge clk);
        in_valid = 1'b0;
        {in_eq, in_gt, in_lt} = 3'b000;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {in_eq, in_gt, in_lt} = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs got rdy/vld=%b%b want 10",
                     in_ready, out_valid);
        end
        checks++;
        if ({digit_cnt, res_eq, res_gt, res_lt, res_err} !== '0) begin
            errors++;
            $display("FAIL reset_out got cnt=%0d res=%b%b%b err=%b want 0",
                     digit_cnt, res_eq, res_gt, res_lt, res_err);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_gt_frame;
        logic [2:0] f [N];
        f = '{F_EQ, F_EQ, F_GT, F_LT};
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL gt_rdy digit %0d got %b want 1", i, in_ready);
            end
            send(f[i], 0);
        end
        checks++;
        if ({out_valid, res_eq, res_gt, res_lt, res_err} !== 5'b10100) begin
            errors++;
            $display("FAIL gt_verdict got v/eq/gt/lt/err=%b want 10100",
                     {out_valid, res_eq, res_gt, res_lt, res_err});
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, res_eq, res_gt, res_lt} !== 5'b10000) begin
            errors++;
            $display("FAIL gt_release got rdy/v/eq/gt/lt=%b want 10000",
                     {in_ready, out_valid, res_eq, res_gt, res_lt});
        end
    endtask

    task automatic test_eq_frame;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (digit_cnt !== CW'(i)) begin
                errors++;
                $display("FAIL eq_cnt got %0d want %0d", digit_cnt, i);
            end
            send(F_EQ, 0);
        end
        checks++;
        if (digit_cnt !== CW'(0)) begin
            errors++;
            $display("FAIL eq_cnt_wrap got %0d want 0", digit_cnt);
        end
        checks++;
        if ({out_valid, res_eq, res_gt, res_lt, res_err} !== 5'b11000) begin
            errors++;
            $display("FAIL eq_verdict got v/eq/gt/lt/err=%b want 11000",
                     {out_valid, res_eq, res_gt, res_lt, res_err});
        end
        @(negedge clk);
    endtask

    task automatic test_msb_backpressure;
        logic [2:0] f [N];
        f = '{F_LT, F_GT, F_GT, F_GT};
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(f[i], 0);
        in_valid = 1'b1;
        {in_eq, in_gt, in_lt} = F_GT;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({in_ready, out_valid, res_eq, res_gt, res_lt, res_err}
                    !== 6'b010010 || digit_cnt !== CW'(0)) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got r/v/eq/gt/lt/err=%b cnt=%0d want 010010 0",
                         c, {in_ready, out_valid, res_eq, res_gt, res_lt,
                         res_err}, digit_cnt);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        {in_eq, in_gt, in_lt} = 3'b000;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || digit_cnt !== CW'(0)
                || {res_eq, res_gt, res_lt} !== 3'b000) begin
            errors++;
            $display("FAIL bp_drop got v=%b cnt=%0d res=%b want 0 0 000",
                     out_valid, digit_cnt, {res_eq, res_gt, res_lt});
        end
    endtask

    task automatic test_illegal;
        logic [2:0] f [N];
        f = '{F_EQ, 3'b110, 3'b000, F_GT};
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(f[i], 0);
        checks++;
        if ({out_valid, res_eq, res_gt, res_lt, res_err} !== 5'b10101) begin
            errors++;
            $display("FAIL ill_verdict got v/eq/gt/lt/err=%b want 10101",
                     {out_valid, res_eq, res_gt, res_lt, res_err});
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) send(F_EQ, 0);
        checks++;
        if ({out_valid, res_eq, res_gt, res_lt, res_err} !== 5'b11000) begin
            errors++;
            $display("FAIL ill_clear got v/eq/gt/lt/err=%b want 11000",
                     {out_valid, res_eq, res_gt, res_lt, res_err});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        out_ready = 1'b1;
        send(F_GT, 0);
        send(F_GT, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (digit_cnt !== CW'(0) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got cnt=%0d v=%b want 0 0",
                     digit_cnt, out_valid);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_early digit %0d got v=%b want 0",
                         i, out_valid);
            end
            send(F_LT, $urandom_range(1, 3));
        end
        checks++;
        if ({out_valid, res_eq, res_gt, res_lt, res_err} !== 5'b10010) begin
            errors++;
            $display("FAIL mid_verdict got v/eq/gt/lt/err=%b want 10010",
                     {out_valid, res_eq, res_gt, res_lt, res_err});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_single got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic [2*N-1:0] a, b;
        logic [1:0]     da, db;
        logic [2:0]     ill [5];
        logic [2:0]     f [N];
        logic           any_ill, dec, eg, eq_e, gt_e, lt_e;
        int             hold;
        ill = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};
        for (int fr = 0; fr < 30; fr++) begin
            a = (2*N)'($urandom);
            b = $urandom_range(0, 3) == 0 ? a : (2*N)'($urandom);
            any_ill = 1'b0;
            for (int k = 0; k < N; k++) begin
                da = a[2*(N-1-k) +: 2];
                db = b[2*(N-1-k) +: 2];
                f[k] = da == db ? F_EQ : (da > db ? F_GT : F_LT);
                if ($urandom_range(0, 4) == 0) begin
                    f[k] = ill[$urandom_range(0, 4)];
                    any_ill = 1'b1;
                end
            end
            if (!any_ill) begin
                eq_e = (a == b);
                gt_e = (a > b);
                lt_e = (a < b);
            end else begin
                dec = 1'b0;
                eg = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!dec && (f[k] == F_GT || f[k] == F_LT)) begin
                        dec = 1'b1;
                        eg = (f[k] == F_GT);
                    end
                end
                eq_e = ~dec;
                gt_e = dec & eg;
                lt_e = dec & ~eg;
            end
            out_ready = 1'b0;
            for (int k = 0; k < N; k++) send(f[k], $urandom_range(0, 2));
            hold = $urandom_range(0, 3);
            for (int c = 0; c <= hold; c++) begin
                checks++;
                if ({out_valid, in_ready, res_eq, res_gt, res_lt, res_err}
                        !== {2'b10, eq_e, gt_e, lt_e, any_ill}) begin
                    errors++;
                    $display("FAIL rnd f%0d a=%h b=%h got v/r/eq/gt/lt/err=%b want %b",
                             fr, a, b, {out_valid, in_ready, res_eq, res_gt,
                             res_lt, res_err},
                             {2'b10, eq_e, gt_e, lt_e, any_ill});
                end
                if (c < hold) @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, res_err} !== 3'b010) begin
                errors++;
                $display("FAIL rnd_rel f%0d got v/r/err=%b want 010",
                         fr, {out_valid, in_ready, res_err});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {in_eq, in_gt, in_lt} = 3'b000;
        @(negedge clk);
        test_reset;
        test_gt_frame;
        test_eq_frame;
        test_msb_backpressure;
        test_illegal;
        test_reset_midframe;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
